weight_buffer: RTL and testbench

//  Weight store and read responder for matrix_multiplication. An upstream loader streams
//  the weight matrix in row-major order (word j*INPUT_WIDTH+i) over a valid/ready port.
//  The buffer then answers the multiplier's weight_addr/weight_read_en requests on weight_data.

---
 rtl/weight_buffer.sv | 160 ++++++++++++++++
 tb/tb_weight_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_buffer.sv
// -----------------------------------------------------------------------------
// weight_buffer
//
// Weight store and zero-latency read responder for the matrix multiplier.
// An upstream loader streams the weight matrix in row-major order
// (word j*INPUT_WIDTH+i) over a valid/ready port. Once the full matrix has
// been accepted, the multiplier reads words through weight_addr/weight_read_en
// and gets weight_data in the same cycle.
//
// Handshake: a load word moves on a rising edge where load_valid=1 and
// load_ready=1 (and load_start=0). load_ready depends only on the FSM state,
// never on load_valid. The loader must hold load_data stable until accepted.
//
// Ports
//   clk            in   clock, all state changes on the rising edge
//   rst_n          in   asynchronous active-low reset
//   load_start     in   pulse: restart loading from word 0 (wins over load_valid)
//   load_valid     in   load_data holds a valid word
//   load_data      in   weight word to store
//   load_ready     out  buffer accepts a word this cycle (state == LOADING)
//   weights_valid  out  full matrix loaded; reads are legal
//   weight_addr    in   read address
//   weight_read_en in   read request
//   weight_data    out  read data (combinational on a read, held value otherwise)
//   rd_err         out  1-cycle pulse the cycle after an illegal read
//   parity_err     out  1-cycle pulse the cycle after a legal read whose
//                       stored parity does not match
//
// Configuration
//   WEIGHT_PARITY_EN  defined: each entry carries an even-parity bit and
//                     parity_err is live. Undefined: no parity bit is stored
//                     and parity_err is constant 0.
// -----------------------------------------------------------------------------
module weight_buffer #(
    parameter int INPUT_WIDTH  = 1152,
    parameter int OUTPUT_WIDTH = 128,
    parameter int DATA_WIDTH   = 16,
    localparam int DEPTH       = INPUT_WIDTH * OUTPUT_WIDTH,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  weights_valid,
    input  logic [AW-1:0]         weight_addr,
    input  logic                  weight_read_en,
    output logic [DATA_WIDTH-1:0] weight_data,
    output logic                  rd_err,
    output logic                  parity_err
);

`ifdef WEIGHT_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    // DEPTH always fits in AW+1 bits, so the range check is done at that width.
    localparam logic [AW:0]   DEPTH_W   = DEPTH[AW:0];
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_LOADING = 2'd1,
        ST_READY   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic                  weights_valid_q, weights_valid_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  rd_err_q, rd_err_d;
    logic                  parity_err_q, parity_err_d;

    // Storage is deliberately not reset.
    logic [MW-1:0] mem [DEPTH];

    logic                  accept;
    logic                  addr_in_range;
    logic                  rd_legal;
    logic [MW-1:0]         rd_entry;
    logic [DATA_WIDTH-1:0] rd_value;
    logic [MW-1:0]         wr_entry;
    logic                  parity_bad;

    assign load_ready    = (state_q == ST_LOADING);
    // A word presented together with load_start is discarded.
    assign accept        = load_valid & load_ready & ~load_start;

    assign addr_in_range = ({1'b0, weight_addr} < DEPTH_W);
    assign rd_legal      = weight_read_en & (state_q == ST_READY) & addr_in_range;
    assign rd_entry      = mem[weight_addr];
    assign rd_value      = rd_legal ? rd_entry[DATA_WIDTH-1:0] : '0;

`ifdef WEIGHT_PARITY_EN
    // Even parity: the stored bit makes the XOR of the whole entry zero.
    assign wr_entry   = {^load_data, load_data};
    assign parity_bad = rd_legal & (^rd_entry);
`else
    assign wr_entry   = load_data;
    assign parity_bad = 1'b0;
`endif

    // On a read the output is the live word (or 0 if illegal); otherwise the
    // value returned by the last read is replayed.
    assign weight_data   = weight_read_en ? rd_value : hold_q;
    assign weights_valid = weights_valid_q;
    assign rd_err        = rd_err_q;
    assign parity_err    = parity_err_q;

    always_comb begin
        state_d         = state_q;
        wr_ptr_d        = wr_ptr_q;
        weights_valid_d = weights_valid_q;
        if (load_start) begin
            state_d         = ST_LOADING;
            wr_ptr_d        = '0;
            weights_valid_d = 1'b0;
        end else if (accept) begin
            if (wr_ptr_q == LAST_ADDR) begin
                wr_ptr_d        = '0;
                weights_valid_d = 1'b1;
                state_d         = ST_READY;
            end else begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
        end
        hold_d       = weight_read_en ? rd_value : hold_q;
        rd_err_d     = weight_read_en & ~rd_legal;
        parity_err_d = parity_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_EMPTY;
            wr_ptr_q        <= '0;
            weights_valid_q <= 1'b0;
            hold_q          <= '0;
            rd_err_q        <= 1'b0;
            parity_err_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            weights_valid_q <= weights_valid_d;
            hold_q          <= hold_d;
            rd_err_q        <= rd_err_d;
            parity_err_q    <= parity_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_weight_buffer.sv
// -----------------------------------------------------------------------------
// tb_weight_buffer
//
// Drives a 4x2 (DEPTH=8) buffer through loads with and without gaps, aborted
// loads, reset mid-load, random read traffic and illegal reads, and a 3x3
// (DEPTH=9) buffer whose address space has out-of-range codes. Expected read
// data comes from a plain array model of "what the loader last delivered"
// plus a flag saying whether a complete matrix is present.
// Define WEIGHT_PARITY_EN for the parity corruption scenario.
// -----------------------------------------------------------------------------
module tb_weight_buffer;

    localparam int IW    = 4;
    localparam int OW    = 2;
    localparam int DW    = 16;
    localparam int DEPTH = IW * OW;
    localparam int AW    = $clog2(DEPTH);

    localparam int DEPTH_O = 9;
    localparam int AW_O    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- main DUT ----------------
    logic          load_start, load_valid, load_ready, weights_valid;
    logic [DW-1:0] load_data, weight_data;
    logic [AW-1:0] weight_addr;
    logic          weight_read_en, rd_err, parity_err;

    weight_buffer #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .DATA_WIDTH(DW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .weights_valid(weights_valid),
        .weight_addr(weight_addr), .weight_read_en(weight_read_en),
        .weight_data(weight_data), .rd_err(rd_err), .parity_err(parity_err)
    );

    // ---------------- odd-depth DUT (has out-of-range addresses) ----------------
    logic            o_load_start, o_load_valid, o_load_ready, o_weights_valid;
    logic [DW-1:0]   o_load_data, o_weight_data;
    logic [AW_O-1:0] o_weight_addr;
    logic            o_weight_read_en, o_rd_err, o_parity_err;

    weight_buffer #(.INPUT_WIDTH(3), .OUTPUT_WIDTH(3), .DATA_WIDTH(DW)) u_odd (
        .clk(clk), .rst_n(rst_n),
        .load_start(o_load_start), .load_valid(o_load_valid), .load_data(o_load_data),
        .load_ready(o_load_ready), .weights_valid(o_weights_valid),
        .weight_addr(o_weight_addr), .weight_read_en(o_weight_read_en),
        .weight_data(o_weight_data), .rd_err(o_rd_err), .parity_err(o_parity_err)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_full;   // a complete matrix is present and readable
    int            ref_wr;     // words accepted so far in the current load
    logic [DW-1:0] ref_hold;   // value returned by the most recent read
    logic [DW-1:0] exp_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        load_start = 0; load_valid = 0; load_data = '0;
        weight_read_en = 0; weight_addr = '0;
        o_load_start = 0; o_load_valid = 0; o_load_data = '0;
        o_weight_read_en = 0; o_weight_addr = '0;
        #3;
        check("rst_load_ready", load_ready, 0);
        check("rst_weights_valid", weights_valid, 0);
        cycle();
        rst_n = 1'b1;
        ref_full = 0; ref_wr = 0; ref_hold = '0;
        #2;
        check("rst_rd_err", rd_err, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_hold_data", weight_data, 0);
        cycle();
    endtask

    task automatic start_load(input bit with_valid);
        load_start = 1;
        load_valid = with_valid;
        load_data  = 16'hDEAD;
        cycle();
        load_start = 0;
        load_valid = 0;
        ref_full = 0; ref_wr = 0;
        check("start_weights_valid", weights_valid, 0);
        check("start_load_ready", load_ready, 1);
    endtask

    // gap_mode: 0 valid always high, 1 toggling 1,0,..., 2 random
    // base < 0 selects random data, otherwise word k carries base+k
    task automatic feed_words(input int n, input int base, input int gap_mode);
        int got = 0;
        int cyc = 0;
        bit v;
        logic [DW-1:0] w;
        while (got < n && cyc < 64 * n + 8) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            w = (base >= 0) ? DW'(base + ref_wr) : DW'($urandom);
            load_valid = v;
            load_data  = v ? w : DW'($urandom);
            #2;
            check("feed_load_ready", load_ready, 1);
            cycle();
            if (v) begin
                ref_mem[ref_wr] = w;
                ref_wr++;
                got++;
                if (ref_wr == DEPTH) begin
                    ref_full = 1;
                    ref_wr   = 0;
                end
            end
            check("feed_weights_valid", weights_valid, 32'(ref_full));
            check("feed_ready_after", load_ready, 32'(!ref_full));
            cyc++;
        end
        load_valid = 0;
        if (got < n) check("feed_timeout", 32'(got), 32'(n));
    endtask

    function automatic logic [DW-1:0] model_read(input int addr);
        return (ref_full && addr < DEPTH) ? ref_mem[addr] : '0;
    endfunction

    task automatic do_read(input int addr, input bit exp_par);
        logic [DW-1:0] exp;
        bit exp_err;
        exp     = model_read(addr);
        exp_err = !(ref_full && addr < DEPTH);
        weight_read_en = 1;
        weight_addr    = AW'(addr);
        #2;
        check($sformatf("rd_data_a%0d", addr), weight_data, exp);
        cycle();
        ref_hold = exp;
        weight_read_en = 0;
        check("rd_err_pulse", rd_err, 32'(exp_err));
        check("rd_parity_pulse", parity_err, 32'(exp_par));
        #2;
        check("rd_hold", weight_data, ref_hold);
        cycle();
        check("rd_err_clear", rd_err, 0);
        check("rd_parity_clear", parity_err, 0);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) do_read(a, 0);
    endtask

    task automatic random_reads(input int n);
        bit en;
        int addr;
        bit exp_err;
        for (int i = 0; i < n; i++) begin
            en   = 1'($urandom_range(0, 1));
            addr = $urandom_range(0, DEPTH - 1);
            weight_read_en = en;
            weight_addr    = AW'(addr);
            exp_q.push_back(en ? model_read(addr) : ref_hold);
            exp_err = en && !ref_full;
            #2;
            check("rand_rd_data", weight_data, exp_q.pop_front());
            cycle();
            if (en) ref_hold = model_read(addr);
            check("rand_rd_err", rd_err, 32'(exp_err));
        end
        weight_read_en = 0;
        cycle();
    endtask

    task automatic odd_read(input int addr, input logic [DW-1:0] exp, input bit exp_err);
        o_weight_read_en = 1;
        o_weight_addr    = AW_O'(addr);
        #2;
        check($sformatf("odd_rd_data_a%0d", addr), o_weight_data, exp);
        cycle();
        o_weight_read_en = 0;
        check($sformatf("odd_rd_err_a%0d", addr), o_rd_err, 32'(exp_err));
        #2;
        check("odd_rd_hold", o_weight_data, exp);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation did not finish");
    end

    // ---------------- main sequence ----------------
    initial begin
        do_reset();

        // Read before anything is loaded.
        do_read(2, 0);

        // Gapless load of 0x0010..0x0017.
        start_load(0);
        feed_words(DEPTH, 16'h0010, 0);
        check("full_weights_valid", weights_valid, 1);
        do_read(5, 0);
        check("addr5_fixed", 32'(ref_hold), 32'h0015);
        read_all();

        // Same data with load_valid toggling.
        start_load(0);
        feed_words(DEPTH, 16'h0010, 1);
        read_all();
        random_reads(24);

        // Reload: reads illegal from the cycle after load_start.
        start_load(0);
        do_read(1, 0);
        feed_words(3, -1, 2);
        random_reads(8);
        // Restart with a valid word on the same cycle; it must be discarded.
        start_load(1);
        feed_words(DEPTH - 1, -1, 2);
        check("partial_weights_valid", weights_valid, 0);
        feed_words(1, -1, 0);
        read_all();
        random_reads(24);

`ifdef WEIGHT_PARITY_EN
        // Corrupt one stored bit; data is still returned, parity_err pulses.
        u_dut.mem[6] = u_dut.mem[6] ^ 17'h0004;
        ref_mem[6]   = ref_mem[6] ^ 16'h0004;
        do_read(6, 1);
        do_read(5, 0);
`endif

        // Reset during a load.
        start_load(0);
        feed_words(4, 16'h0300, 0);
        do_reset();
        check("midrst_load_ready", load_ready, 0);
        check("midrst_weights_valid", weights_valid, 0);
        do_read(0, 0);

        // Odd-depth instance: last legal address and out-of-range codes.
        o_load_start = 1;
        cycle();
        o_load_start = 0;
        for (int k = 0; k < DEPTH_O; k++) begin
            o_load_valid = 1;
            o_load_data  = DW'(16'h0100 + k);
            cycle();
        end
        o_load_valid = 0;
        check("odd_weights_valid", o_weights_valid, 1);
        check("odd_load_ready", o_load_ready, 0);
        odd_read(8, 16'h0108, 0);
        odd_read(0, 16'h0100, 0);
        odd_read(9, 16'h0000, 1);
        odd_read(15, 16'h0000, 1);
        cycle();
        check("odd_rd_err_clear", o_rd_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
